// File: rtl/ycbcr444_to_422.sv
// YCbCr 4:4:4 to 4:2:2 decimator: averages chroma over pixel pairs, beats 1 cycle after pixel1 handshake.
// Output beats sit in a 4-entry FIFO; input tready comes from phase and FIFO count only.

module ycbcr_fifo2w #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push0,
  input  logic [W-1:0] i_dat0,
  input  logic         i_push1,
  input  logic [W-1:0] i_dat1,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_vld,
  output logic [2:0]   o_cnt
);
  logic [W-1:0] r_mem [4];
  logic [1:0]   r_wr;
  logic [1:0]   r_rd;
  logic [2:0]   r_cnt;
  logic [1:0]   w_wr1;
  logic         w_pop;

  assign w_wr1 = r_wr + 2'd1;
  assign w_pop = i_pop && (r_cnt != 3'd0);

  // i_push1 is only ever asserted together with i_push0
  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr] <= i_dat0;
    if (i_push1) r_mem[w_wr1] <= i_dat1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= 2'd0;
      r_rd  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      r_wr  <= r_wr + {1'b0, i_push0} + {1'b0, i_push1};
      r_rd  <= r_rd + {1'b0, w_pop};
      r_cnt <= r_cnt + {2'b0, i_push0} + {2'b0, i_push1} - {2'b0, w_pop};
    end
  end

  assign o_vld = (r_cnt != 3'd0);
  assign o_dat = o_vld ? r_mem[r_rd] : '0;
  assign o_cnt = r_cnt;
endmodule

module ycbcr444_to_422 #(
  parameter int CHROMA_ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [15:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser,
  output logic        sync_err
);
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

  phase_t      r_phase;
  phase_t      w_phase_nxt;
  logic [23:0] r_p0;
  logic        r_p0_user;
  logic        r_sync_err;
  logic        w_acc;
  logic        w_err;
  logic        w_push0;
  logic        w_push1;
  logic [17:0] w_dat0;
  logic [17:0] w_dat1;
  logic [17:0] w_fifo_dat;
  logic        w_fifo_vld;
  logic [2:0]  w_cnt;
  logic [8:0]  w_rnd;
  logic [8:0]  w_cb_sum;
  logic [8:0]  w_cr_sum;

  assign w_rnd    = (CHROMA_ROUND != 0) ? 9'd1 : 9'd0;
  assign w_cb_sum = {1'b0, r_p0[15:8]}  + {1'b0, s_axis_video_tdata[15:8]}  + w_rnd;
  assign w_cr_sum = {1'b0, r_p0[23:16]} + {1'b0, s_axis_video_tdata[23:16]} + w_rnd;

  // ODD reserves room for a full pair, EVEN only for a possible lone odd-width beat
  assign s_axis_video_tready = ~rst &
      ((r_phase == EVEN) ? (w_cnt <= 3'd3) : (w_cnt <= 3'd2));
  assign w_acc = s_axis_video_tvalid && s_axis_video_tready;

  always_comb begin
    w_phase_nxt = r_phase;
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    w_dat0      = '0;
    w_dat1      = '0;
    w_err       = 1'b0;
    if (w_acc) begin
      if (r_phase == ODD && !s_axis_video_tuser) begin
        w_push0     = 1'b1;
        w_push1     = 1'b1;
        w_dat0      = {r_p0_user, 1'b0, w_cb_sum[8:1], r_p0[7:0]};
        w_dat1      = {1'b0, s_axis_video_tlast, w_cr_sum[8:1], s_axis_video_tdata[7:0]};
        w_phase_nxt = EVEN;
      end else begin
        w_err = (r_phase == ODD);
        if (s_axis_video_tlast) begin
          w_push0     = 1'b1;
          w_dat0      = {s_axis_video_tuser, 1'b1, s_axis_video_tdata[15:0]};
          w_phase_nxt = EVEN;
        end else begin
          w_phase_nxt = ODD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= EVEN;
      r_p0       <= 24'd0;
      r_p0_user  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_sync_err <= w_err;
      if (w_acc && w_phase_nxt == ODD) begin
        r_p0      <= s_axis_video_tdata;
        r_p0_user <= s_axis_video_tuser;
      end
    end
  end

  ycbcr_fifo2w #(.W(18)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push0 (w_push0),
    .i_dat0  (w_dat0),
    .i_push1 (w_push1),
    .i_dat1  (w_dat1),
    .i_pop   (m_axis_video_tready),
    .o_dat   (w_fifo_dat),
    .o_vld   (w_fifo_vld),
    .o_cnt   (w_cnt)
  );

  assign m_axis_video_tvalid = w_fifo_vld;
  assign m_axis_video_tdata  = w_fifo_dat[15:0];
  assign m_axis_video_tlast  = w_fifo_dat[16];
  assign m_axis_video_tuser  = w_fifo_dat[17];
  assign sync_err            = r_sync_err;
endmodule

// File: doc/ycbcr444_to_422.md
YCBCR444_TO_422 -- requirements
Module: ycbcr444_to_422

Interface
REQ-001 SHALL have parameter CHROMA_ROUND, default 1: 1 = chroma average rounds half-up, 0 = truncates.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port s_axis_video_tdata, input, 24, pixel {Cr[23:16], Cb[15:8], Y[7:0]}.
REQ-005 SHALL have port s_axis_video_tvalid, input, 1, input beat valid.
REQ-006 SHALL have port s_axis_video_tready, output, 1, input beat accepted when high with tvalid.
REQ-007 SHALL have port s_axis_video_tlast, input, 1, last pixel of line.
REQ-008 SHALL have port s_axis_video_tuser, input, 1, first pixel of frame.
REQ-009 SHALL have port m_axis_video_tdata, output, 16, 4:2:2 beat {C[15:8], Y[7:0]}.
REQ-010 SHALL have port m_axis_video_tvalid, output, 1, output beat valid.
REQ-011 SHALL have port m_axis_video_tready, input, 1, downstream accepts.
REQ-012 SHALL have port m_axis_video_tlast, output, 1, last beat of line.
REQ-013 SHALL have port m_axis_video_tuser, output, 1, first beat of frame.
REQ-014 SHALL have port sync_err, output, 1, one-cycle pulse on a discarded half-pair.

Function
REQ-015 SHALL track pixel phase with two states: EVEN (no pixel held) and ODD (pixel0 held in P0 register with its tuser).
REQ-016 SHALL buffer output beats in a 4-entry FIFO (data, tlast, tuser); m_axis_video_tvalid = FIFO non-empty; pop on tvalid&&tready.
REQ-017 SHALL drive s_axis_video_tready from registered state only: EVEN -> FIFO count <= 3; ODD -> FIFO count <= 2; never from m_axis_video_tready combinationally.
REQ-018 EVEN, accepted beat with tlast=0: SHALL store pixel in P0, go ODD, no FIFO write.
REQ-019 ODD, accepted beat with tuser=0: SHALL push beat A {Cb_avg, Y0} (tuser = P0 tuser, tlast=0) then beat B {Cr_avg, Y1} (tuser=0, tlast = input tlast) in the same cycle, go EVEN.
REQ-020 Cb_avg = (Cb0 + Cb1 + CHROMA_ROUND) >> 1 in 9-bit intermediate; Cr_avg likewise; no overflow or saturation possible.
REQ-021 EVEN, accepted beat with tlast=1 (odd line width): SHALL push single beat {Cb, Y} of that pixel, unaveraged, with its tuser and tlast=1; stay EVEN.
REQ-022 ODD, accepted beat with tuser=1: SHALL discard P0, pulse sync_err, treat new beat as pixel0 per REQ-018/REQ-021.
REQ-023 Simultaneous FIFO push and pop SHALL be supported; count updates by pushes minus pop.
REQ-024 Latency: first output beat valid 1 cycle after the pixel1 (or lone odd-width pixel) input handshake.
REQ-025 With m_axis_video_tready held high, SHALL sustain one input pixel per cycle with no bubbles.
REQ-026 Output beat SHALL hold data/tlast/tuser stable while tvalid=1 and tready=0.

Reset
REQ-027 While rst=1: s_axis_video_tready=0, m_axis_video_tvalid=0, m_axis_video_tdata=0, tlast=0, tuser=0, sync_err=0, FIFO empty, phase EVEN, P0 cleared.
REQ-028 Reset asserted mid-pair or with FIFO non-empty SHALL drop all held and buffered data; first cycle after release s_axis_video_tready=1.

Verification
REQ-029 Pair: inputs {Cr,Cb,Y}=0x804020 tuser=1, then 0x824222 tlast=1, m_tready=1 -> beats 0x4120 tuser=1, then 0x8122 tlast=1.
REQ-030 Rounding: Cb 0x01 and 0x02, CHROMA_ROUND=1 -> C=0x02; CHROMA_ROUND=0 -> C=0x01; Cb 0xFF,0xFF -> 0xFF.
REQ-031 Odd width: 3-pixel line Y=0x10,0x11,0x12, Cb of pixel 2=0x55 -> 3 beats, last 0x5512 with tlast=1, phase back to EVEN.
REQ-032 Backpressure: m_tready=0 with continuous valid input -> s_tready drops after 2 pairs (count 4); no beat lost or duplicated once m_tready=1.
REQ-033 Misalignment: pixel0 held, next beat tuser=1 -> sync_err pulses 1 cycle, old pixel absent from output, new frame pairs correctly.
REQ-034 Reset mid-stream with 3 beats queued -> all outputs 0 during reset, no stale beats after release.
